// File: rtl/cavlc_write_total_zeros.sv
// CAVLC total_zeros encoder: maps (TotalCoeff, TotalZeros) to its VLC codeword
// with a one-deep registered output stage and per-slice bit/symbol counters.
module cavlc_write_total_zeros #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             chroma_DC_sel,
  input  logic [3:0]       TotalCoeff,
  input  logic [3:0]       TotalZeros,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       code,
  output logic [3:0]       len,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] bit_total,
  output logic [CNT_W-1:0] sym_total
);

  localparam int unsigned CODE_W = 9;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // {len, code} for 4x4 blocks; unreachable entries return 0
  function automatic logic [LEN_W+CODE_W-1:0] vlc_4x4(input logic [3:0] tc,
                                                     input logic [3:0] tz);
    logic [LEN_W+CODE_W-1:0] v;
    v = '0;
    case (tc)
      4'd1: case (tz)
        4'd0:  v = {4'd1, 9'b1};         4'd1:  v = {4'd3, 9'b011};
        4'd2:  v = {4'd3, 9'b010};       4'd3:  v = {4'd4, 9'b0011};
        4'd4:  v = {4'd4, 9'b0010};      4'd5:  v = {4'd5, 9'b00011};
        4'd6:  v = {4'd5, 9'b00010};     4'd7:  v = {4'd6, 9'b000011};
        4'd8:  v = {4'd6, 9'b000010};    4'd9:  v = {4'd7, 9'b0000011};
        4'd10: v = {4'd7, 9'b0000010};   4'd11: v = {4'd8, 9'b00000011};
        4'd12: v = {4'd8, 9'b00000010};  4'd13: v = {4'd9, 9'b000000011};
        4'd14: v = {4'd9, 9'b000000010}; 4'd15: v = {4'd9, 9'b000000001};
        default: v = '0;
      endcase
      4'd2: case (tz)
        4'd0:  v = {4'd3, 9'b111};    4'd1:  v = {4'd3, 9'b110};
        4'd2:  v = {4'd3, 9'b101};    4'd3:  v = {4'd3, 9'b100};
        4'd4:  v = {4'd3, 9'b011};    4'd5:  v = {4'd4, 9'b0101};
        4'd6:  v = {4'd4, 9'b0100};   4'd7:  v = {4'd4, 9'b0011};
        4'd8:  v = {4'd4, 9'b0010};   4'd9:  v = {4'd5, 9'b00011};
        4'd10: v = {4'd5, 9'b00010};  4'd11: v = {4'd6, 9'b000011};
        4'd12: v = {4'd6, 9'b000010}; 4'd13: v = {4'd6, 9'b000001};
        4'd14: v = {4'd6, 9'b000000};
        default: v = '0;
      endcase
      4'd3: case (tz)
        4'd0:  v = {4'd4, 9'b0101};   4'd1:  v = {4'd3, 9'b111};
        4'd2:  v = {4'd3, 9'b110};    4'd3:  v = {4'd3, 9'b101};
        4'd4:  v = {4'd4, 9'b0100};   4'd5:  v = {4'd4, 9'b0011};
        4'd6:  v = {4'd3, 9'b100};    4'd7:  v = {4'd3, 9'b011};
        4'd8:  v = {4'd4, 9'b0010};   4'd9:  v = {4'd5, 9'b00011};
        4'd10: v = {4'd5, 9'b00010};  4'd11: v = {4'd6, 9'b000001};
        4'd12: v = {4'd5, 9'b00001};  4'd13: v = {4'd6, 9'b000000};
        default: v = '0;
      endcase
      4'd4: case (tz)
        4'd0:  v = {4'd5, 9'b00011};  4'd1:  v = {4'd3, 9'b111};
        4'd2:  v = {4'd4, 9'b0101};   4'd3:  v = {4'd4, 9'b0100};
        4'd4:  v = {4'd3, 9'b110};    4'd5:  v = {4'd3, 9'b101};
        4'd6:  v = {4'd3, 9'b100};    4'd7:  v = {4'd4, 9'b0011};
        4'd8:  v = {4'd3, 9'b011};    4'd9:  v = {4'd4, 9'b0010};
        4'd10: v = {4'd5, 9'b00010};  4'd11: v = {4'd5, 9'b00001};
        4'd12: v = {4'd5, 9'b00000};
        default: v = '0;
      endcase
      4'd5: case (tz)
        4'd0:  v = {4'd4, 9'b0101};   4'd1:  v = {4'd4, 9'b0100};
        4'd2:  v = {4'd4, 9'b0011};   4'd3:  v = {4'd3, 9'b111};
        4'd4:  v = {4'd3, 9'b110};    4'd5:  v = {4'd3, 9'b101};
        4'd6:  v = {4'd3, 9'b100};    4'd7:  v = {4'd3, 9'b011};
        4'd8:  v = {4'd4, 9'b0010};   4'd9:  v = {4'd5, 9'b00001};
        4'd10: v = {4'd4, 9'b0001};   4'd11: v = {4'd5, 9'b00000};
        default: v = '0;
      endcase
      4'd6: case (tz)
        4'd0:  v = {4'd6, 9'b000001}; 4'd1:  v = {4'd5, 9'b00001};
        4'd2:  v = {4'd3, 9'b111};    4'd3:  v = {4'd3, 9'b110};
        4'd4:  v = {4'd3, 9'b101};    4'd5:  v = {4'd3, 9'b100};
        4'd6:  v = {4'd3, 9'b011};    4'd7:  v = {4'd3, 9'b010};
        4'd8:  v = {4'd4, 9'b0001};   4'd9:  v = {4'd3, 9'b001};
        4'd10: v = {4'd6, 9'b000000};
        default: v = '0;
      endcase
      4'd7: case (tz)
        4'd0:  v = {4'd6, 9'b000001}; 4'd1:  v = {4'd5, 9'b00001};
        4'd2:  v = {4'd3, 9'b101};    4'd3:  v = {4'd3, 9'b100};
        4'd4:  v = {4'd3, 9'b011};    4'd5:  v = {4'd2, 9'b11};
        4'd6:  v = {4'd3, 9'b010};    4'd7:  v = {4'd4, 9'b0001};
        4'd8:  v = {4'd3, 9'b001};    4'd9:  v = {4'd6, 9'b000000};
        default: v = '0;
      endcase
      4'd8: case (tz)
        4'd0:  v = {4'd6, 9'b000001}; 4'd1:  v = {4'd4, 9'b0001};
        4'd2:  v = {4'd5, 9'b00001};  4'd3:  v = {4'd3, 9'b011};
        4'd4:  v = {4'd2, 9'b11};     4'd5:  v = {4'd2, 9'b10};
        4'd6:  v = {4'd3, 9'b010};    4'd7:  v = {4'd3, 9'b001};
        4'd8:  v = {4'd6, 9'b000000};
        default: v = '0;
      endcase
      4'd9: case (tz)
        4'd0:  v = {4'd6, 9'b000001}; 4'd1:  v = {4'd6, 9'b000000};
        4'd2:  v = {4'd4, 9'b0001};   4'd3:  v = {4'd2, 9'b11};
        4'd4:  v = {4'd2, 9'b10};     4'd5:  v = {4'd3, 9'b001};
        4'd6:  v = {4'd2, 9'b01};     4'd7:  v = {4'd5, 9'b00001};
        default: v = '0;
      endcase
      4'd10: case (tz)
        4'd0:  v = {4'd5, 9'b00001};  4'd1:  v = {4'd5, 9'b00000};
        4'd2:  v = {4'd3, 9'b001};    4'd3:  v = {4'd2, 9'b11};
        4'd4:  v = {4'd2, 9'b10};     4'd5:  v = {4'd2, 9'b01};
        4'd6:  v = {4'd4, 9'b0001};
        default: v = '0;
      endcase
      4'd11: case (tz)
        4'd0:  v = {4'd4, 9'b0000};   4'd1:  v = {4'd4, 9'b0001};
        4'd2:  v = {4'd3, 9'b001};    4'd3:  v = {4'd3, 9'b010};
        4'd4:  v = {4'd1, 9'b1};      4'd5:  v = {4'd3, 9'b011};
        default: v = '0;
      endcase
      4'd12: case (tz)
        4'd0:  v = {4'd4, 9'b0000};   4'd1:  v = {4'd4, 9'b0001};
        4'd2:  v = {4'd2, 9'b01};     4'd3:  v = {4'd1, 9'b1};
        4'd4:  v = {4'd3, 9'b001};
        default: v = '0;
      endcase
      4'd13: case (tz)
        4'd0:  v = {4'd3, 9'b000};    4'd1:  v = {4'd3, 9'b001};
        4'd2:  v = {4'd1, 9'b1};      4'd3:  v = {4'd2, 9'b01};
        default: v = '0;
      endcase
      4'd14: case (tz)
        4'd0:  v = {4'd2, 9'b00};     4'd1:  v = {4'd2, 9'b01};
        4'd2:  v = {4'd1, 9'b1};
        default: v = '0;
      endcase
      4'd15: case (tz)
        4'd0:  v = {4'd1, 9'b0};      4'd1:  v = {4'd1, 9'b1};
        default: v = '0;
      endcase
      default: v = '0;
    endcase
    return v;
  endfunction

  // {len, code} for chroma DC 2x2 blocks
  function automatic logic [LEN_W+CODE_W-1:0] vlc_cdc(input logic [3:0] tc,
                                                     input logic [3:0] tz);
    logic [LEN_W+CODE_W-1:0] v;
    v = '0;
    case ({tc, tz})
      8'h10: v = {4'd1, 9'b1};
      8'h11: v = {4'd2, 9'b01};
      8'h12: v = {4'd3, 9'b001};
      8'h13: v = {4'd3, 9'b000};
      8'h20: v = {4'd1, 9'b1};
      8'h21: v = {4'd2, 9'b01};
      8'h22: v = {4'd2, 9'b00};
      8'h30: v = {4'd1, 9'b1};
      8'h31: v = {4'd1, 9'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;
  logic              err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]  bit_total_q, bit_total_d;
  logic [CNT_W-1:0]  sym_total_q, sym_total_d;

  logic              accept;
  logic              deliver;
  logic              illegal;
  logic [4:0]        coeff_sum;
  logic [LEN_W+CODE_W-1:0] vlc;
  logic [SUM_W-1:0]  bit_sum;

  assign in_ready = !out_valid_q || out_ready;

  // Input legality and codeword lookup
  always_comb begin
    coeff_sum = 5'(TotalCoeff) + 5'(TotalZeros);
    illegal   = (TotalCoeff == 4'd0) ||
                (!chroma_DC_sel && (coeff_sum > 5'd16)) ||
                (chroma_DC_sel && ((TotalCoeff > 4'd3) || (coeff_sum > 5'd4)));
    vlc       = chroma_DC_sel ? vlc_cdc(TotalCoeff, TotalZeros)
                              : vlc_4x4(TotalCoeff, TotalZeros);
    if (illegal) vlc = '0;
  end

  // Next state of output stage and accumulators; clr beats a same-cycle delivery
  always_comb begin
    accept       = in_valid && in_ready;
    deliver      = out_valid_q && out_ready;
    out_valid_d  = out_valid_q;
    code_d       = code_q;
    len_d        = len_q;
    err_d        = err_q;
    err_sticky_d = err_sticky_q;
    bit_total_d  = bit_total_q;
    sym_total_d  = sym_total_q;
    bit_sum      = SUM_W'(bit_total_q) + SUM_W'(len_q);

    if (accept) begin
      out_valid_d = 1'b1;
      len_d       = vlc[LEN_W+CODE_W-1:CODE_W];
      code_d      = vlc[CODE_W-1:0];
      err_d       = illegal;
      if (illegal) err_sticky_d = 1'b1;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end

    if (clr) begin
      bit_total_d  = '0;
      sym_total_d  = '0;
      err_sticky_d = 1'b0;
    end else if (deliver) begin
      bit_total_d = bit_sum[CNT_W] ? CNT_MAX : bit_sum[CNT_W-1:0];
      sym_total_d = (sym_total_q == CNT_MAX) ? CNT_MAX : sym_total_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      code_q       <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      bit_total_q  <= '0;
      sym_total_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      code_q       <= code_d;
      len_q        <= len_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      bit_total_q  <= bit_total_d;
      sym_total_q  <= sym_total_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign code       = code_q;
  assign len        = len_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign bit_total  = bit_total_q;
  assign sym_total  = sym_total_q;

endmodule

// File: tb/tb_cavlc_write_total_zeros.sv
// Bench for cavlc_write_total_zeros: string-table codeword model, prefix parser,
// cycle model of the handshake/counters, directed and random stimulus.
module tb_cavlc_write_total_zeros;

  localparam int CNT_W = 16;
  localparam int CMAX  = 65535;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             chroma_DC_sel = 1'b0;
  logic [3:0]       TotalCoeff = '0;
  logic [3:0]       TotalZeros = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [8:0]       code;
  logic [3:0]       len;
  logic             err;
  logic             err_sticky;
  logic [CNT_W-1:0] bit_total;
  logic [CNT_W-1:0] sym_total;

  int checks = 0;
  int errors = 0;

  cavlc_write_total_zeros #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .chroma_DC_sel(chroma_DC_sel), .TotalCoeff(TotalCoeff), .TotalZeros(TotalZeros),
    .out_valid(out_valid), .out_ready(out_ready), .code(code), .len(len), .err(err),
    .err_sticky(err_sticky), .bit_total(bit_total), .sym_total(sym_total)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Codeword tables as text, one space-separated token per TotalZeros value
  function automatic string row_4x4(input int tc);
    case (tc)
      1:  return "1 011 010 0011 0010 00011 00010 000011 000010 0000011 0000010 00000011 00000010 000000011 000000010 000000001";
      2:  return "111 110 101 100 011 0101 0100 0011 0010 00011 00010 000011 000010 000001 000000";
      3:  return "0101 111 110 101 0100 0011 100 011 0010 00011 00010 000001 00001 000000";
      4:  return "00011 111 0101 0100 110 101 100 0011 011 0010 00010 00001 00000";
      5:  return "0101 0100 0011 111 110 101 100 011 0010 00001 0001 00000";
      6:  return "000001 00001 111 110 101 100 011 010 0001 001 000000";
      7:  return "000001 00001 101 100 011 11 010 0001 001 000000";
      8:  return "000001 0001 00001 011 11 10 010 001 000000";
      9:  return "000001 000000 0001 11 10 001 01 00001";
      10: return "00001 00000 001 11 10 01 0001";
      11: return "0000 0001 001 010 1 011";
      12: return "0000 0001 01 1 001";
      13: return "000 001 1 01";
      14: return "00 01 1";
      15: return "0 1";
      default: return "";
    endcase
  endfunction

  function automatic string row_cdc(input int tc);
    case (tc)
      1: return "1 01 001 000";
      2: return "1 01 00";
      3: return "1 0";
      default: return "";
    endcase
  endfunction

  function automatic bit is_illegal(input bit ch, input int tc, input int tz);
    return (tc == 0) || (!ch && tc + tz > 16) || (ch && (tc > 3 || tc + tz > 4));
  endfunction

  // Reference codeword: pick the tz-th token of the row
  function automatic void ref_cw(input bit ch, input int tc, input int tz,
                                 output logic [8:0] c, output int l, output bit e);
    string row;
    int idx;
    byte b;
    c = '0;
    l = 0;
    e = is_illegal(ch, tc, tz);
    if (e) return;
    row = ch ? row_cdc(tc) : row_4x4(tc);
    idx = 0;
    for (int i = 0; i < row.len(); i++) begin
      b = row.getc(i);
      if (b == 8'h20) idx++;
      else if (idx == tz) begin
        c = {c[7:0], b == 8'h31};
        l++;
      end
    end
  endfunction

  // Parser model: decode a bit stream (codeword then noise) by prefix match
  function automatic void parse_tz(input bit ch, input int tc, input logic [8:0] c,
                                   input int l, input logic [15:0] noise,
                                   output int tz, output int used);
    string row;
    logic [15:0] s;
    int idx, pos;
    bit ok;
    byte b;
    s = (16'(c) << (16 - l)) | (noise & 16'((32'd1 << (16 - l)) - 1));
    row = ch ? row_cdc(tc) : row_4x4(tc);
    tz = -1; used = 0; idx = 0; pos = 0; ok = 1'b1;
    for (int i = 0; i <= row.len(); i++) begin
      b = (i == row.len()) ? 8'h20 : row.getc(i);
      if (b == 8'h20) begin
        if (ok && pos > 0 && tz < 0) begin tz = idx; used = pos; end
        idx++; pos = 0; ok = 1'b1;
      end else begin
        if (pos > 15 || s[15 - pos] != (b == 8'h31)) ok = 1'b0;
        pos++;
      end
    end
  endfunction

  // Cycle model of the handshake, output stage and counters
  bit m_ov = 0, m_err = 0, m_sticky = 0, m_ch = 0;
  logic [8:0] m_code = '0;
  int m_len = 0, m_bits = 0, m_syms = 0, m_tc = 0, m_tz = 0;

  always @(posedge clk or negedge rst_n) begin
    bit acc, dlv;
    if (!rst_n) begin
      m_ov = 0; m_err = 0; m_sticky = 0; m_code = '0; m_len = 0; m_bits = 0; m_syms = 0;
    end else begin
      acc = in_valid && (!m_ov || out_ready);
      dlv = m_ov && out_ready;
      if (clr) begin
        m_bits = 0; m_syms = 0;
      end else if (dlv) begin
        m_bits = (m_bits + m_len > CMAX) ? CMAX : m_bits + m_len;
        m_syms = (m_syms + 1 > CMAX) ? CMAX : m_syms + 1;
      end
      if (acc) begin
        m_ch = chroma_DC_sel; m_tc = int'(TotalCoeff); m_tz = int'(TotalZeros);
        ref_cw(m_ch, m_tc, m_tz, m_code, m_len, m_err);
        m_ov = 1;
        if (m_err) m_sticky = 1;
      end else if (dlv) begin
        m_ov = 0;
      end
      if (clr) m_sticky = 0;
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    int dtz, dused;
    if (rst_n) begin
      check("out_valid", out_valid, m_ov);
      check("in_ready", in_ready, !m_ov || out_ready);
      check("err_sticky", err_sticky, m_sticky);
      check("bit_total", bit_total, m_bits);
      check("sym_total", sym_total, m_syms);
      if (m_ov) begin
        check("code", code, m_code);
        check("len", len, m_len);
        check("err", err, m_err);
        if (!m_err) begin
          parse_tz(m_ch, m_tc, code, int'(len), 16'($urandom), dtz, dused);
          check("parse_tz", dtz, m_tz);
          check("parse_len", dused, len);
        end
      end
    end
  end

  task automatic drive(input bit v, input bit ch, input int tc, input int tz,
                       input bit ordy, input bit c = 1'b0);
    in_valid = v; chroma_DC_sel = ch; TotalCoeff = 4'(tc); TotalZeros = 4'(tz);
    out_ready = ordy; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic pin(input string name, input bit ch, input int tc, input int tz,
                     input int exp_code, input int exp_len, input bit exp_err);
    logic [8:0] c; int l; bit e;
    ref_cw(ch, tc, tz, c, l, e);
    check({name, "_code"}, c, exp_code);
    check({name, "_len"}, l, exp_len);
    check({name, "_err"}, e, exp_err);
  endtask

  initial begin
    int mx, tz;
    // Model pins
    pin("pin_tc1_tz15", 0, 1, 15, 1, 9, 0);
    pin("pin_tc2_tz4", 0, 2, 4, 3, 3, 0);
    pin("pin_tc3_tz0", 0, 3, 0, 5, 4, 0);
    pin("pin_tc14_tz1", 0, 14, 1, 1, 2, 0);
    pin("pin_cdc_tc1_tz3", 1, 1, 3, 0, 3, 0);
    pin("pin_cdc_tc3_tz1", 1, 3, 1, 0, 1, 0);
    pin("pin_tc5_tz12", 0, 5, 12, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_len", len, 0);
    check("rst_bit_total", bit_total, 0);
    rst_n = 1'b1;

    // Longest 4x4 codeword
    drive(1, 0, 1, 15, 1);
    check("t1_valid", out_valid, 1);
    check("t1_code", code, 1);
    check("t1_len", len, 9);
    drive(0, 0, 0, 0, 1);
    check("t1_bits", bit_total, 9);
    check("t1_syms", sym_total, 1);

    // Chroma DC back-to-back
    drive(1, 1, 1, 3, 1);
    check("t2a_code", code, 0);
    check("t2a_len", len, 3);
    chroma_DC_sel = 1; TotalCoeff = 4'd3; TotalZeros = 4'd1; #1;
    check("t2_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("t2b_code", code, 0);
    check("t2b_len", len, 1);
    drive(0, 0, 0, 0, 1);

    // Stall with a pending symbol
    drive(1, 0, 2, 4, 0);
    repeat (3) begin
      in_valid = 1; TotalCoeff = 4'd7; TotalZeros = 4'd0; chroma_DC_sel = 0; #1;
      check("t3_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("t3_code", code, 3);
      check("t3_len", len, 3);
    end
    drive(1, 0, 7, 0, 1);
    check("t3_next_code", code, 1);
    check("t3_next_len", len, 6);
    drive(0, 0, 0, 0, 1);

    // Illegal symbol, then clr
    drive(1, 0, 5, 12, 1);
    check("t4_err", err, 1);
    check("t4_len", len, 0);
    check("t4_sticky", err_sticky, 1);
    drive(0, 0, 0, 0, 1, 1);
    check("t4_clr_sticky", err_sticky, 0);
    check("t4_clr_bits", bit_total, 0);
    check("t4_clr_syms", sym_total, 0);

    // Full sweep of legal pairs in both tables
    for (int ch = 0; ch < 2; ch++) begin
      mx = ch ? 4 : 16;
      for (int tc = 1; tc <= (ch ? 3 : 15); tc++)
        for (int z = 0; z <= mx - tc; z++) drive(1, ch[0], tc, z, 1);
    end
    drive(0, 0, 0, 0, 1);

    // Random traffic, mostly legal
    repeat (3000) begin
      bit ch;
      int tc;
      ch = 1'($urandom_range(0, 1));
      tc = ch ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15));
      mx = ch ? 4 : 16;
      if ($urandom_range(0, 7) == 0 || tc >= mx) tz = int'($urandom_range(0, 15));
      else tz = int'($urandom_range(0, mx - tc));
      drive($urandom_range(0, 3) != 0, ch, tc, tz, $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0);
    end

    // Saturation with len-1 symbols
    drive(0, 0, 0, 0, 1, 1);
    in_valid = 1; chroma_DC_sel = 0; TotalCoeff = 4'd15; TotalZeros = 4'd0;
    out_ready = 1; clr = 0;
    repeat (65540) @(posedge clk);
    #1;
    check("sat_bits", bit_total, CMAX);
    check("sat_syms", sym_total, CMAX);
    drive(0, 0, 0, 0, 1);

    // Asynchronous reset during a stall
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("t6_stalled", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_bits", bit_total, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) drive(0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
